// File: rtl/dff_pipe_pkg.sv
// Purpose: shared sizing helpers for the stallable register pipeline.
// Latency: n/a (compile-time functions only).
// Backpressure: n/a.
package dff_pipe_pkg;

    // Bits needed to encode values 0..n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int occ_w(input int depth);
        return cnt_w(depth + 1);
    endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// Purpose: one pipeline stage, a valid bit plus a WIDTH-bit data register.
// Latency: 1 cycle from load to output.
// Backpressure: none locally; load/clear come from the top-level advance chain.
//
// Ports:
//   clock, r_n   rising-edge clock, asynchronous active-low reset
//   load         capture d and mark the stage valid
//   clear        drop the valid bit (ignored when load is also high)
//   d            incoming word
//   valid, data  registered stage contents
module dff_pipe_stage #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             r_n,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } stage_t;

    stage_t r;

    // Data only changes on a load, so an emptied stage keeps its last word.
    always_ff @(posedge clock or negedge r_n) begin
        if (!r_n) begin
            r <= '{valid: 1'b0, data: RESET_VAL};
        end else if (load) begin
            r <= '{valid: 1'b1, data: d};
        end else if (clear) begin
            r.valid <= 1'b0;
        end
    end

    assign valid = r.valid;
    assign data  = r.data;

endmodule

// File: rtl/dff_pipe_stall.sv
// Purpose: WIDTH x DEPTH register pipeline with per-stage valid bits and bubble collapse.
// Latency: DEPTH cycles input-to-output when nothing ahead is stalled; 1 word/cycle throughput.
// Backpressure: lossless; in_ready is combinational from out_ready through the advance chain.
//
// Ports:
//   clock, r_n           rising-edge clock, asynchronous active-low reset
//   flush                synchronous clear of every stage valid bit
//   in_valid/in_ready    producer handshake, in_data captured when both high
//   out_valid/out_ready  consumer handshake, out_data is the last stage register
//   occupancy            number of valid stages
module dff_pipe_stall
    import dff_pipe_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clock,
    input  logic                       r_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [occ_w(DEPTH)-1:0]    occupancy
);

    localparam int OCC_W = occ_w(DEPTH);

    logic [DEPTH-1:0]            v;
    logic [DEPTH-1:0]            adv;
    logic [DEPTH-1:0]            load;
    logic [DEPTH-1:0]            clr;
    logic [DEPTH-1:0][WIDTH-1:0] q;

    // A stage moves forward when its successor is empty or is itself moving,
    // so gaps between words close up while the head is stalled.
    always_comb begin
        adv            = '0;
        adv[DEPTH-1]   = v[DEPTH-1] & out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv[i] = v[i] & (~v[i+1] | adv[i+1]);
        end
    end

    assign in_ready = ~flush & (~v[0] | adv[0]);

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] d;

        if (i == 0) begin : g_head
            assign load[i] = in_valid & in_ready;
            assign d       = in_data;
        end else begin : g_body
            // Flush wins over any forward move.
            assign load[i] = adv[i-1] & ~flush;
            assign d       = q[i-1];
        end

        // A stage whose word leaves empties unless it is refilled the same edge.
        assign clr[i] = flush | adv[i];

        dff_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clock (clock),
            .r_n   (r_n),
            .load  (load[i]),
            .clear (clr[i]),
            .d     (d),
            .valid (v[i]),
            .data  (q[i])
        );
    end

    assign out_valid = v[DEPTH-1];
    assign out_data  = q[DEPTH-1];

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(v[i]);
        end
    end

endmodule

// File: tb/tb_dff_pipe_stall.sv
// Purpose: scoreboard bench for dff_pipe_stall (WIDTH=8, DEPTH=4, RESET_VAL=8'hA5).
// Latency: words accepted are expected back in order, DEPTH cycles later when free-flowing.
// Backpressure: exercised through stalls, bubbles, flush and asynchronous reset.
module tb_dff_pipe_stall;

    localparam int         WIDTH = 8;
    localparam int         DEPTH = 4;
    localparam logic [7:0] RVAL  = 8'hA5;

    logic       clock = 1'b0;
    logic       r_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] occupancy;

    always #5 clock = ~clock;

    dff_pipe_stall #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL (RVAL)
    ) dut (
        .clock     (clock),
        .r_n       (r_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    bit   lat_chk = 1'b0;
    int   accepts;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Samples both handshakes just before the edge, then advances one clock.
    task automatic step();
        exp_t e;
        #1;
        if (in_valid && in_ready) begin
            sb.push_back('{data: in_data, cyc: cyc});
            accepts++;
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("out_data", 32'(out_data), 32'(e.data));
                if (lat_chk) chk("latency", 32'(cyc - e.cyc), 32'(DEPTH));
            end
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain(input string tag);
        int n;
        n         = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (sb.size() > 0 && n < 20) begin
            step();
            n++;
        end
        chk(tag, 32'(sb.size()), 32'd0);
        chk({tag, "_occ"}, 32'(occupancy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        r_n       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        accepts   = 0;

        // Reset state
        #12;
        chk("rst_out_data",  32'(out_data),  32'(RVAL));
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_occ",       32'(occupancy), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        r_n = 1'b1;
        @(posedge clock);
        #1;

        // Free flow: push/pop overlap once full, occupancy steady at DEPTH
        lat_chk   = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i + 1);
            if (i >= DEPTH) begin
                chk("ff_occ",      32'(occupancy), 32'(DEPTH));
                chk("ff_in_ready", 32'(in_ready),  32'd1);
            end
            step();
        end
        drain("ff_drain");
        lat_chk = 1'b0;

        // Backpressure: six offered, four accepted, state holds while full
        out_ready = 1'b0;
        accepts   = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h30 + i);
            step();
        end
        in_valid = 1'b0;
        chk("bp_accepts",  32'(accepts),   32'd4);
        chk("bp_occ",      32'(occupancy), 32'(DEPTH));
        chk("bp_in_ready", 32'(in_ready),  32'd0);
        chk("bp_head",     32'(out_data),  32'h30);
        idle(2);
        chk("bp_hold_occ",  32'(occupancy), 32'(DEPTH));
        chk("bp_hold_head", 32'(out_data),  32'h30);
        drain("bp_drain");

        // Bubble collapse under a stalled head
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h11;
        step();
        idle(2);
        in_valid = 1'b1;
        in_data  = 8'h22;
        step();
        idle(4);
        chk("bub_occ",       32'(occupancy), 32'd2);
        chk("bub_in_ready",  32'(in_ready),  32'd1);
        chk("bub_out_valid", 32'(out_valid), 32'd1);
        chk("bub_head",      32'(out_data),  32'h11);
        drain("bub_drain");

        // Flush with a word offered in the same cycle
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h41 + i);
            step();
        end
        idle(2);
        chk("fl_pre_occ", 32'(occupancy), 32'd3);
        in_valid = 1'b1;
        in_data  = 8'h99;
        flush    = 1'b1;
        #1;
        chk("fl_in_ready",  32'(in_ready),  32'd0);
        chk("fl_out_valid", 32'(out_valid), 32'd1);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        chk("fl_occ",       32'(occupancy), 32'd0);
        chk("fl_out_valid_after", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        idle(DEPTH + 1);
        chk("fl_no_capture", 32'(occupancy), 32'd0);

        // Asynchronous reset mid-stream, then resume with normal latency
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h61 + i);
            step();
        end
        idle(2);
        chk("ar_pre_occ", 32'(occupancy), 32'd3);
        #3;
        r_n = 1'b0;
        #1;
        chk("ar_out_data",  32'(out_data),  32'(RVAL));
        chk("ar_out_valid", 32'(out_valid), 32'd0);
        chk("ar_occ",       32'(occupancy), 32'd0);
        chk("ar_in_ready",  32'(in_ready),  32'd1);
        sb.delete();
        @(negedge clock);
        r_n = 1'b1;
        @(posedge clock);
        #1;
        lat_chk   = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h51 + i);
            step();
        end
        drain("ar_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
